// File: rtl/key_pkg.sv
// Shared definitions for the push-button front end and the key-event encoder.
package key_pkg;

  // Buttons are active-low; this is the released level.
  localparam logic KEY_IDLE = 1'b1;

  // 10 ms at 50 MHz.
  localparam int unsigned STABLE_CYCLES_DEFAULT = 500000;

  // Event codes understood by the downstream encoder.
  typedef enum logic [2:0] {
    NOP = 3'b000,
    K0  = 3'b100,
    K1  = 3'b101,
    K2  = 3'b110,
    K3  = 3'b111
  } key_event_e;

  // Per-key filter state.
  typedef enum logic {
    StStable,
    StCount
  } filt_state_e;

  // Counter width able to hold 0..stable inclusive.
  function automatic int unsigned cnt_width(input int unsigned stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One key: synchroniser, stability counter, two-state filter, level and pulse registers.
module debounce_cell
  import key_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_raw_i,
  output logic key_o,
  output logic key_next_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  filt_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   accept;

  // Plain flop chain; only stage 0 sees the asynchronous pin.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{KEY_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Filter state, counter, level and pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StStable;
      cnt_q     <= '0;
      level_q   <= KEY_IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // A new level is accepted once the counter has reached the limit and s still differs.
  assign accept = (state_q == StCount) && (s != level_q) && (cnt_q == CNT_MAX);

  // Next-state: leave STABLE on any difference, return on a glitch or on acceptance.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStable: if (s != level_q) state_d = StCount;
      StCount:  if ((s == level_q) || accept) state_d = StStable;
      default:  state_d = StStable;
    endcase
  end

  // Outputs: counter update, level flip and the matching one-cycle pulse.
  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StStable: begin
        if (s != level_q) cnt_d = CNT_W'(1);
      end
      StCount: begin
        if (s == level_q) begin
          cnt_d = '0;
        end else if (accept) begin
          cnt_d     = '0;
          level_d   = s;
          press_d   = ~s;
          release_d = s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign key_o      = level_q;
  assign key_next_o = level_d;
  assign press_o    = press_q;
  assign release_o  = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Push-button front end: N_KEYS independent debounce cells plus a registered any-pressed flag.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_KEYS-1:0] key_raw_i,
  output logic [N_KEYS-1:0] key_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic              any_pressed_o
);

  logic [N_KEYS-1:0] key_next;
  logic              any_pressed_q;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_cell
    debounce_cell #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .key_raw_i  (key_raw_i[k]),
      .key_o      (key_o[k]),
      .key_next_o (key_next[k]),
      .press_o    (press_o[k]),
      .release_o  (release_o[k])
    );
  end

  // Built from the cells' next level so it updates in the same cycle as key_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      any_pressed_q <= 1'b0;
    end else begin
      any_pressed_q <= |(~key_next);
    end
  end

  assign any_pressed_o = any_pressed_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer with STABLE_CYCLES=8, SYNC_STAGES=2.
module tb_key_debouncer;

  localparam int SC = 8;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] raw = 4'b0000;
  logic [3:0] key, press, rel;
  logic       any;

  int n_tests = 0;
  int n_fail  = 0;
  int press_cnt[4] = '{0, 0, 0, 0};

  key_debouncer #(
    .N_KEYS        (4),
    .SYNC_STAGES   (SS),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .key_raw_i     (raw),
    .key_o         (key),
    .press_o       (press),
    .release_o     (rel),
    .any_pressed_o (any)
  );

  always #5 clk = ~clk;

  // Model: a key flips when its synchronised sample has disagreed with the
  // current level on SC+1 consecutive edges (first edge starts the run).
  logic [3:0] m_sync[SS];
  logic [3:0] m_key   = 4'hf;
  logic [3:0] m_press = 4'h0;
  logic [3:0] m_rel   = 4'h0;
  logic       m_any   = 1'b0;
  int         m_cyc   = 0;
  int         m_last[4] = '{0, 0, 0, 0};

  initial begin
    for (int i = 0; i < SS; i++) m_sync[i] = 4'hf;
    forever begin : model
      logic [3:0] s;
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < SS; i++) m_sync[i] = 4'hf;
        m_key = 4'hf; m_press = 4'h0; m_rel = 4'h0; m_any = 1'b0;
        for (int k = 0; k < 4; k++) m_last[k] = m_cyc;
      end else begin
        s = m_sync[SS-1];
        for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = raw;
        m_cyc++;
        m_press = 4'h0; m_rel = 4'h0;
        for (int k = 0; k < 4; k++) begin
          if (s[k] == m_key[k]) begin
            m_last[k] = m_cyc;
          end else if (m_cyc - m_last[k] == SC + 1) begin
            m_key[k]  = s[k];
            m_last[k] = m_cyc;
            if (s[k]) m_rel[k] = 1'b1;
            else      m_press[k] = 1'b1;
          end
        end
        m_any = |(~m_key);
      end
    end
  end

  // Compare DUT with model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({key, press, rel, any} !== {m_key, m_press, m_rel, m_any}) begin
        n_fail++;
        $display("FAIL model t=%0t key/press/rel/any got %b/%b/%b/%b want %b/%b/%b/%b", $time,
                 key, press, rel, any, m_key, m_press, m_rel, m_any);
      end
      for (int k = 0; k < 4; k++) if (press[k] === 1'b1) press_cnt[k]++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  int p0;

  initial begin
    #1 rst = 1'b1;
    // 1. Reset with keys held.
    raw = 4'b0000;
    step(2);
    chk("rst_key", key, 4'b1111);
    chk("rst_press", press, 4'b0000);
    chk("rst_rel", rel, 4'b0000);
    chk("rst_any", {3'b000, any}, 4'b0000);
    rst = 1'b0;
    step(10);
    chk("held_early_key", key, 4'b1111);
    step(1);
    chk("held_press", press, 4'b1111);
    chk("held_key", key, 4'b0000);
    chk("held_any", {3'b000, any}, 4'b0001);
    step(1);
    chk("held_press_width", press, 4'b0000);
    raw = 4'b1111;
    step(11);
    chk("held_release", rel, 4'b1111);
    step(2);

    // 2. Clean press and release of key0.
    raw = 4'b1110;
    step(10);
    chk("clean_early", key, 4'b1111);
    step(1);
    chk("clean_key", key, 4'b1110);
    chk("clean_press", press, 4'b0001);
    step(1);
    chk("clean_press_width", press, 4'b0000);
    raw = 4'b1111;
    step(10);
    chk("clean_rel_early", key, 4'b1110);
    step(1);
    chk("clean_rel_key", key, 4'b1111);
    chk("clean_rel", rel, 4'b0001);
    step(1);
    chk("clean_rel_width", rel, 4'b0000);

    // 3. Bounce on key1 then hold low.
    p0 = press_cnt[1];
    for (int i = 0; i < 10; i++) begin
      raw[1] = ~raw[1];
      step(3);
      chk("bounce_level", key, 4'b1111);
    end
    raw[1] = 1'b0;
    step(10);
    chk("bounce_early", key, 4'b1111);
    step(1);
    chk("bounce_key", key, 4'b1101);
    chk("bounce_press", press, 4'b0010);
    step(2);
    chk("bounce_one_pulse", 4'(press_cnt[1] - p0), 4'd1);
    raw = 4'b1111;
    step(13);

    // 4. Glitch threshold on key2.
    p0 = press_cnt[2];
    raw[2] = 1'b0;
    step(7);
    raw[2] = 1'b1;
    step(15);
    chk("glitch7_key", key, 4'b1111);
    chk("glitch7_nopulse", 4'(press_cnt[2] - p0), 4'd0);
    raw[2] = 1'b0;
    step(12);
    chk("long_key", key, 4'b1011);
    chk("long_pulse", 4'(press_cnt[2] - p0), 4'd1);
    raw = 4'b1111;
    step(13);

    // 5. Simultaneous keys 2 and 3, then release only key2.
    raw = 4'b0011;
    step(11);
    chk("simul_press", press, 4'b1100);
    chk("simul_key", key, 4'b0011);
    raw = 4'b0111;
    step(11);
    chk("indep_rel", rel, 4'b0100);
    chk("indep_key", key, 4'b0111);
    chk("indep_any", {3'b000, any}, 4'b0001);
    raw = 4'b1111;
    step(13);

    // 6. Reset while key0 is mid-count.
    raw = 4'b1110;
    step(7);
    rst = 1'b1;
    #1;
    chk("midrst_key", key, 4'b1111);
    chk("midrst_press", press, 4'b0000);
    step(1);
    rst = 1'b0;
    step(10);
    chk("midrst_early", key, 4'b1111);
    step(1);
    chk("midrst_press_after", press, 4'b0001);
    chk("midrst_key_after", key, 4'b1110);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
